// File: rtl/beep_decoder.sv
// beep_decoder: measures the period of a buzzer-style square wave and
// classifies it to one of seven note codes (DO..XI). A code change is
// reported only after several consecutive identical classifications.
// Long silence (no rising edge) drops back to IDLE and clears the code.
module beep_decoder #(
    parameter logic [17:0] DO         = 18'd190800,
    parameter logic [17:0] RE         = 18'd170000,
    parameter logic [17:0] MI         = 18'd151500,
    parameter logic [17:0] FA         = 18'd143100,
    parameter logic [17:0] SO         = 18'd127500,
    parameter logic [17:0] LA         = 18'd113600,
    parameter logic [17:0] XI         = 18'd101200,
    parameter logic [17:0] TOL        = 18'd2000,
    parameter logic [2:0]  STABLE_CNT = 3'd3,
    parameter logic [19:0] TIMEOUT    = 20'd400000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        beep_in,
    output logic [2:0]  note_code,
    output logic        note_valid,
    output logic [19:0] period,
    output logic        active
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t      state_r;

    logic        sync1_r;
    logic        sync2_r;
    logic        dly_r;
    logic        edge_r;

    logic [19:0] per_cnt_r;
    logic [19:0] meas_r;
    logic        meas_vld_r;
    logic [2:0]  cand_r;
    logic        cand_vld_r;
    logic [2:0]  prev_cand_r;
    logic [2:0]  match_cnt_r;

    logic [19:0] meas_next_s;
    logic [2:0]  cand_next_s;
    logic [2:0]  match_next_s;
    logic        timeout_s;

    // True when measured period m lies within +/-TOL of reference ref_p.
    // A 21-bit signed difference keeps the subtraction free of wrap-around.
    function automatic logic in_window(input logic [19:0] m, input logic [17:0] ref_p);
        logic signed [20:0] diff;
        logic signed [20:0] tol_s;
        diff      = $signed({1'b0, m}) - $signed({3'b000, ref_p});
        tol_s     = $signed({3'b000, TOL});
        in_window = (diff <= tol_s) && (diff >= -tol_s);
    endfunction

    // Input synchronizer, delay stage and registered rising-edge pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            dly_r   <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= beep_in;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
            edge_r  <= sync2_r & ~dly_r;
        end
    end

    // Next-measurement value, timeout detect, classifier and match counter.
    always_comb begin
        if (per_cnt_r == {20{1'b1}}) begin
            meas_next_s = per_cnt_r;
        end else begin
            meas_next_s = per_cnt_r + 20'd1;
        end

        timeout_s = (state_r == MEAS) && !edge_r && (per_cnt_r == (TIMEOUT - 20'd1));

        // Priority chain: the lowest code wins when windows overlap.
        if (in_window(meas_r, DO)) begin
            cand_next_s = 3'd1;
        end else if (in_window(meas_r, RE)) begin
            cand_next_s = 3'd2;
        end else if (in_window(meas_r, MI)) begin
            cand_next_s = 3'd3;
        end else if (in_window(meas_r, FA)) begin
            cand_next_s = 3'd4;
        end else if (in_window(meas_r, SO)) begin
            cand_next_s = 3'd5;
        end else if (in_window(meas_r, LA)) begin
            cand_next_s = 3'd6;
        end else if (in_window(meas_r, XI)) begin
            cand_next_s = 3'd7;
        end else begin
            cand_next_s = 3'd0;
        end

        if (cand_r == prev_cand_r) begin
            if (match_cnt_r >= STABLE_CNT) begin
                match_next_s = STABLE_CNT;
            end else begin
                match_next_s = match_cnt_r + 3'd1;
            end
        end else begin
            match_next_s = 3'd1;
        end
    end

    // Free-running saturating period counter, restarted by every rising edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            per_cnt_r <= 20'd0;
        end else if (edge_r) begin
            per_cnt_r <= 20'd0;
        end else if (per_cnt_r != {20{1'b1}}) begin
            per_cnt_r <= per_cnt_r + 20'd1;
        end else begin
            per_cnt_r <= per_cnt_r;
        end
    end

    // FSM plus measure -> classify -> stability pipeline with registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r     <= IDLE;
            meas_r      <= 20'd0;
            meas_vld_r  <= 1'b0;
            cand_r      <= 3'd0;
            cand_vld_r  <= 1'b0;
            prev_cand_r <= 3'd0;
            match_cnt_r <= 3'd0;
            note_code   <= 3'd0;
            note_valid  <= 1'b0;
            period      <= 20'd0;
            active      <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            meas_vld_r <= 1'b0;
            cand_vld_r <= meas_vld_r;

            if (meas_vld_r) begin
                cand_r <= cand_next_s;
            end

            // Stability stage: update the run of identical candidates.
            if (cand_vld_r) begin
                match_cnt_r <= match_next_s;
                if (cand_r != prev_cand_r) begin
                    prev_cand_r <= cand_r;
                end
                if ((match_next_s == STABLE_CNT) && (cand_r != note_code)) begin
                    note_code  <= cand_r;
                    note_valid <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    // The arming edge only restarts the period counter.
                    if (edge_r) begin
                        state_r <= MEAS;
                        active  <= 1'b1;
                    end
                end
                MEAS: begin
                    if (edge_r) begin
                        meas_r     <= meas_next_s;
                        period     <= meas_next_s;
                        meas_vld_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r     <= IDLE;
                        active      <= 1'b0;
                        match_cnt_r <= 3'd0;
                        prev_cand_r <= 3'd0;
                        if (note_code != 3'd0) begin
                            note_code  <= 3'd0;
                            note_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beep_decoder.sv
// tb_beep_decoder: scoreboard bench for beep_decoder. The reference model
// works on gaps between driven rising edges; expected note changes are
// queued with their expected arrival cycle and checked by a monitor.
module tb_beep_decoder;

    localparam int TOL_P     = 2;
    localparam int STABLE_P  = 3;
    localparam int TIMEOUT_P = 400;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        beep_in;
    logic [2:0]  note_code;
    logic        note_valid;
    logic [19:0] period;
    logic        active;

    beep_decoder #(
        .DO(18'd150), .RE(18'd100), .MI(18'd50), .FA(18'd25),
        .SO(18'd15), .LA(18'd10), .XI(18'd5), .TOL(18'd2),
        .STABLE_CNT(3'd3), .TIMEOUT(20'd400)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .beep_in(beep_in),
        .note_code(note_code), .note_valid(note_valid),
        .period(period), .active(active)
    );

    // 50 MHz clock
    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int code;
        int per;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  notes[7] = '{150, 100, 50, 25, 15, 10, 5};

    // reference model state
    int m_armed, m_prev_v, m_last_d, m_code, m_prev, m_mc, m_period;

    function automatic int classify_ref(int p);
        for (int k = 0; k < 7; k++) begin
            if (p >= notes[k] - TOL_P && p <= notes[k] + TOL_P) return k + 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_prev_v = 0; m_last_d = 0;
        m_code = 0; m_prev = 0; m_mc = 0; m_period = 0;
    endtask

    task automatic push_ev(int code, int per, int at);
        ev_t e;
        e.code = code; e.per = per; e.at = at;
        exp_q.push_back(e);
    endtask

    // Advance the model by one driven cycle with beep_in value v.
    task automatic model_tick(int v);
        int d, gap, c;
        d = cyc;
        if (m_armed != 0 && d - m_last_d == TIMEOUT_P + 1) begin
            if (m_code != 0) push_ev(0, m_period, m_last_d + 1 + TIMEOUT_P + 3);
            m_code = 0; m_mc = 0; m_prev = 0; m_armed = 0;
        end
        if (v != 0 && m_prev_v == 0) begin
            if (m_armed == 0) begin
                m_armed = 1;
            end else begin
                gap = d - m_last_d;
                m_period = gap;
                c = classify_ref(gap);
                if (c == m_prev) begin
                    m_mc = (m_mc + 1 > STABLE_P) ? STABLE_P : m_mc + 1;
                end else begin
                    m_mc = 1;
                    m_prev = c;
                end
                if (m_mc == STABLE_P && c != m_code) begin
                    m_code = c;
                    push_ev(c, gap, d + 6);
                end
            end
            m_last_d = d;
        end
        m_prev_v = v;
    endtask

    task automatic cmp(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic drive(int v);
        @(negedge sys_clk);
        model_tick(v);
        beep_in = (v != 0);
    endtask

    task automatic period_once(int p);
        int h;
        h = p / 2;
        repeat (h) drive(1);
        repeat (p - h) drive(0);
    endtask

    task automatic tone(int p, int n);
        repeat (n) period_once(p);
    endtask

    task automatic idle_low(int n);
        repeat (n) drive(0);
    endtask

    task automatic check_now(string name);
        cmp({name, "_code"}, int'(note_code), m_code);
        cmp({name, "_period"}, int'(period), m_period);
        cmp({name, "_active"}, int'(active), m_armed);
    endtask

    task automatic check_state(string name);
        idle_low(8);
        check_now(name);
    endtask

    // Monitor: every note_valid pulse must match the head of the queue.
    always @(negedge sys_clk) begin
        if (sys_rst == 1'b0 && note_valid == 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got code %0d at cycle %0d expected no pulse",
                         note_code, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (int'(note_code) != e.code || int'(period) != e.per || cyc != e.at) begin
                    miscompares++;
                    $display("FAIL pulse: got code %0d period %0d cycle %0d expected code %0d period %0d cycle %0d",
                             note_code, period, cyc, e.code, e.per, e.at);
                end
            end
        end
    end

    initial begin
        int sel, p, reps, off;
        sys_rst = 1'b1;
        beep_in = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_now("reset");
        cmp("reset_valid", int'(note_valid), 0);
        sys_rst = 1'b0;

        // 1: period 100 locks after the fourth rising edge
        tone(100, 2);
        check_now("t1_two_edges");
        cmp("t1_period100", int'(period), 100);
        tone(100, 2);
        check_now("t1_locked");
        cmp("t1_code_re", int'(note_code), 2);
        cmp("t1_active", int'(active), 1);

        // 2: switch to period 50
        tone(50, 4);
        check_now("t2");
        cmp("t2_code_mi", int'(note_code), 3);

        // 3: edge of tolerance, out of window, silence
        tone(102, 4);
        check_now("t3_102");
        cmp("t3_code_re", int'(note_code), 2);
        tone(75, 4);
        check_now("t3_75");
        cmp("t3_code_zero", int'(note_code), 0);
        idle_low(450);
        check_now("t3_silence");
        tone(103, 5);
        check_now("t3_103");
        cmp("t3_103_code", int'(note_code), 0);

        // 4: timeout from code 3, then re-arm
        tone(50, 4);
        check_now("t4_pre");
        idle_low(450);
        check_now("t4_timeout");
        cmp("t4_active_low", int'(active), 0);
        cmp("t4_period_held", int'(period), 50);
        tone(50, 4);
        check_now("t4_rearm");
        cmp("t4_code_mi", int'(note_code), 3);

        // 5: alternating periods never stabilise
        repeat (10) begin
            period_once(100);
            period_once(50);
        end
        check_now("t5_alt");
        cmp("t5_code_kept", int'(note_code), 3);

        // 6: asynchronous reset mid-note
        tone(100, 4);
        check_now("t6_pre");
        repeat (20) drive(1);
        @(negedge sys_clk);
        #3 sys_rst = 1'b1;
        #1;
        cmp("t6_rst_code", int'(note_code), 0);
        cmp("t6_rst_valid", int'(note_valid), 0);
        cmp("t6_rst_period", int'(period), 0);
        cmp("t6_rst_active", int'(active), 0);
        cmp("t6_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        beep_in = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        tone(100, 3);
        check_now("t6_three_edges");
        cmp("t6_not_locked", int'(note_code), 0);
        tone(100, 1);
        check_now("t6_relocked");
        cmp("t6_code_re", int'(note_code), 2);

        // randomized segments
        for (int s = 0; s < 30; s++) begin
            sel  = $urandom_range(0, 5);
            reps = $urandom_range(1, 5);
            case (sel)
                0, 1: begin
                    p = notes[$urandom_range(0, 6)];
                    tone(p, reps);
                end
                2: begin
                    off = $urandom_range(0, 3);
                    p = notes[$urandom_range(0, 6)];
                    case (off)
                        0: p = p - 3;
                        1: p = p - 2;
                        2: p = p + 2;
                        default: p = p + 3;
                    endcase
                    tone(p, reps);
                end
                3: begin
                    p = $urandom_range(5, 300);
                    tone(p, reps);
                end
                4: begin
                    p = ($urandom_range(0, 1) == 0) ? 400 : 401;
                    tone(p, $urandom_range(1, 2));
                end
                default: begin
                    idle_low(420 + $urandom_range(0, 60));
                end
            endcase
            check_state("rand");
        end

        idle_low(10);
        cmp("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
